// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-issue ALU execute stage.
// Single-cycle ops (add/sub/logic/compare/shift/lui/jr) answer one cycle
// after acceptance. MUL/MULH/MULHU/DIV/DIVU/REM/REMU iterate one bit per
// cycle and answer DWIDTH+1 cycles after acceptance.
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_valid / o_ready        operation handshake (accepted in IDLE only)
//   i_funct, i_alu_src       op code, operand-B select (1 = sign-extended imm)
//   i_data_rs, i_data_rt     operand A, register operand B
//   i_imm                    immediate
//   i_flush                  aborts any in-flight operation
//   o_valid                  one-cycle result strobe
//   o_value, o_pc            result, jump target (held between strobes)
//   o_change_pc              redirect request, qualified by o_valid
module alu_exec_unit #(
  parameter int DWIDTH    = 32,
  parameter int PC_WIDTH  = 32,
  parameter int IMM_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [4:0]           i_funct,
  input  logic                 i_alu_src,
  input  logic [DWIDTH-1:0]    i_data_rs,
  input  logic [DWIDTH-1:0]    i_data_rt,
  input  logic [IMM_WIDTH-1:0] i_imm,
  input  logic                 i_flush,
  output logic                 o_valid,
  output logic [DWIDTH-1:0]    o_value,
  output logic [PC_WIDTH-1:0]  o_pc,
  output logic                 o_change_pc
);

  localparam int SHW = $clog2(DWIDTH);
  localparam int CW  = $clog2(DWIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  typedef enum logic [4:0] {
    F_ADD  = 5'd0,  F_SUB  = 5'd1,  F_AND   = 5'd2,  F_OR   = 5'd3,
    F_NOR  = 5'd4,  F_SLT  = 5'd5,  F_SLTU  = 5'd6,  F_SLL  = 5'd7,
    F_SRL  = 5'd8,  F_SRA  = 5'd9,  F_EQ    = 5'd10, F_NEQ  = 5'd11,
    F_GE   = 5'd12, F_GEU  = 5'd13, F_ADDU  = 5'd14, F_SUBU = 5'd17,
    F_LUI  = 5'd18, F_JR   = 5'd19, F_MUL   = 5'd20, F_MULH = 5'd21,
    F_MULHU= 5'd22, F_DIV  = 5'd23, F_DIVU  = 5'd24, F_REM  = 5'd25,
    F_REMU = 5'd26
  } funct_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4:0]            op_q, op_d;
  logic [DWIDTH-1:0]     hi_q, hi_d, lo_q, lo_d, mc_q, mc_d, a_q, a_d;
  logic                  bz_q, bz_d, negq_q, negq_d, negr_q, negr_d;
  logic [DWIDTH-1:0]     res_q, res_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  chg_q, chg_d;
  logic [DWIDTH-1:0]     val_hold_q;
  logic [PC_WIDTH-1:0]   pc_hold_q;
  logic                  chg_hold_q;

  logic [DWIDTH-1:0]     opb, abs_a, abs_b;
  logic [SHW-1:0]        sh;
  logic                  sgn_a, sgn_b, is_iter, is_signed_iter;
  logic [DWIDTH-1:0]     sc_val;
  logic [PC_WIDTH-1:0]   sc_pc;
  logic                  sc_chg;

  logic [DWIDTH:0]       mul_sum, div_sh, div_tr;
  logic [DWIDTH-1:0]     step_hi, step_lo, quo, rem, fin;
  logic [2*DWIDTH-1:0]   prod, prod_n;

  assign opb   = i_alu_src ? {{(DWIDTH-IMM_WIDTH){i_imm[IMM_WIDTH-1]}}, i_imm} : i_data_rt;
  assign sh    = opb[SHW-1:0];
  assign sgn_a = i_data_rs[DWIDTH-1];
  assign sgn_b = opb[DWIDTH-1];
  assign abs_a = sgn_a ? -i_data_rs : i_data_rs;
  assign abs_b = sgn_b ? -opb : opb;
  assign is_iter        = (i_funct >= 5'd20) && (i_funct <= 5'd26);
  assign is_signed_iter = (i_funct == F_MULH) || (i_funct == F_DIV) || (i_funct == F_REM);

  always_comb begin
    sc_val = '0;
    sc_pc  = '0;
    sc_chg = 1'b0;
    case (i_funct)
      F_ADD, F_ADDU: sc_val = i_data_rs + opb;
      F_SUB, F_SUBU: sc_val = i_data_rs - opb;
      F_AND:  sc_val = i_data_rs & opb;
      F_OR:   sc_val = i_data_rs | opb;
      F_NOR:  sc_val = ~(i_data_rs | opb);
      F_SLT:  sc_val[0] = $signed(i_data_rs) < $signed(opb);
      F_SLTU: sc_val[0] = i_data_rs < opb;
      F_SLL:  sc_val = i_data_rs << sh;
      F_SRL:  sc_val = i_data_rs >> sh;
      F_SRA:  sc_val = $signed(i_data_rs) >>> sh;
      F_EQ:   sc_val[0] = i_data_rs == opb;
      F_NEQ:  sc_val[0] = i_data_rs != opb;
      F_GE:   sc_val[0] = $signed(i_data_rs) >= $signed(opb);
      F_GEU:  sc_val[0] = i_data_rs >= opb;
      F_LUI:  sc_val = {i_imm, {(DWIDTH-IMM_WIDTH){1'b0}}};
      F_JR: begin
        sc_pc  = i_data_rs[PC_WIDTH-1:0];
        sc_chg = 1'b1;
      end
      default: ;
    endcase
  end

  // Shared hi/lo datapath: multiply keeps {acc, multiplier} and shifts right;
  // divide keeps {remainder, dividend->quotient} and shifts left.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : '0);
    div_sh  = {hi_q, lo_q[DWIDTH-1]};
    div_tr  = div_sh - {1'b0, mc_q};
    if (op_q >= 5'd23) begin
      if (!div_tr[DWIDTH]) begin
        step_hi = div_tr[DWIDTH-1:0];
        step_lo = {lo_q[DWIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_sh[DWIDTH-1:0];
        step_lo = {lo_q[DWIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[DWIDTH:1];
      step_lo = {mul_sum[0], lo_q[DWIDTH-1:1]};
    end
    prod   = {step_hi, step_lo};
    prod_n = negq_q ? -prod : prod;
    quo    = negq_q ? -step_lo : step_lo;
    rem    = negr_q ? -step_hi : step_hi;
    case (op_q)
      F_MUL:        fin = prod[DWIDTH-1:0];
      F_MULH:       fin = prod_n[2*DWIDTH-1:DWIDTH];
      F_MULHU:      fin = prod[2*DWIDTH-1:DWIDTH];
      F_DIV, F_DIVU: fin = bz_q ? '1 : quo;
      F_REM, F_REMU: fin = bz_q ? a_q : rem;
      default:      fin = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mc_d    = mc_q;
    a_d     = a_q;
    bz_d    = bz_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    res_d   = res_q;
    pc_d    = pc_q;
    chg_d   = chg_q;
    if (i_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            op_d   = i_funct;
            a_d    = i_data_rs;
            bz_d   = (opb == '0);
            hi_d   = '0;
            lo_d   = i_data_rs;
            mc_d   = opb;
            negq_d = 1'b0;
            negr_d = 1'b0;
            cnt_d  = '0;
            if (is_signed_iter) begin
              lo_d   = abs_a;
              mc_d   = abs_b;
              negq_d = sgn_a ^ sgn_b;
              negr_d = sgn_a;
            end
            if (is_iter) begin
              state_d = S_BUSY;
              pc_d    = '0;
              chg_d   = 1'b0;
            end else begin
              state_d = S_DONE;
              res_d   = sc_val;
              pc_d    = sc_pc;
              chg_d   = sc_chg;
            end
          end
        end
        S_BUSY: begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(DWIDTH)) begin
            state_d = S_DONE;
            res_d   = fin;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      mc_q       <= '0;
      a_q        <= '0;
      bz_q       <= 1'b0;
      negq_q     <= 1'b0;
      negr_q     <= 1'b0;
      res_q      <= '0;
      pc_q       <= '0;
      chg_q      <= 1'b0;
      val_hold_q <= '0;
      pc_hold_q  <= '0;
      chg_hold_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mc_q    <= mc_d;
      a_q     <= a_d;
      bz_q    <= bz_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      res_q   <= res_d;
      pc_q    <= pc_d;
      chg_q   <= chg_d;
      if (o_valid) begin
        val_hold_q <= res_q;
        pc_hold_q  <= pc_q;
        chg_hold_q <= chg_q;
      end
    end
  end

  // A flush or reset in DONE kills the strobe, so outputs only move on o_valid.
  assign o_ready     = (state_q == S_IDLE);
  assign o_valid     = (state_q == S_DONE) && !i_flush && !i_rst;
  assign o_value     = o_valid ? res_q : val_hold_q;
  assign o_pc        = o_valid ? pc_q  : pc_hold_q;
  assign o_change_pc = o_valid ? chg_q : chg_hold_q;

endmodule
